// File: rtl/segment_sequencer_pkg.sv
// Shared types and constants for the segment sequencer: FSM states,
// seven-segment glyphs and the built-in message table.
package seg_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    ARM  = 2'd1,
    USER = 2'd2
  } state_t;

  localparam logic [7:0] SEG_H     = 8'h76;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_L     = 8'h38;
  localparam logic [7:0] SEG_O     = 8'h3F;
  localparam logic [7:0] SEG_W     = 8'h4F;
  localparam logic [7:0] SEG_r     = 8'h50;
  localparam logic [7:0] SEG_d     = 8'h5E;
  localparam logic [7:0] SEG_DP    = 8'h80;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // "HELLO WOrLd . . " with blanks between the trailing dots
  localparam logic [7:0] MSG [16] = '{
    SEG_H, SEG_E, SEG_L, SEG_L, SEG_O, SEG_BLANK, SEG_W, SEG_O,
    SEG_r, SEG_L, SEG_d, SEG_BLANK, SEG_DP, SEG_BLANK, SEG_DP, SEG_BLANK
  };

endpackage

// File: rtl/segment_msg_rom.sv
// Combinational lookup of the message glyph at a given index.
module segment_msg_rom
  import seg_pkg::*;
(
  input  logic [3:0] addr,
  output logic [7:0] pattern
);

  assign pattern = MSG[addr];

endmodule

// File: rtl/segment_sequencer.sv
// Frame-synchronous scheduler for the renderer's segment pattern: plays the
// built-in message, hands over to debounced user input, and times back out.
module segment_sequencer
  import seg_pkg::*;
#(
  parameter int HOLD_FRAMES     = 32,
  parameter int MSG_LEN         = 16,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int IDLE_TIMEOUT    = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync_in,
  input  logic [7:0] ui_in,
  output logic [7:0] led_pattern,
  output logic       show_user,
  output logic [3:0] char_index,
  output logic [9:0] frame_count,
  output logic       frame_tick
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  state_t          state;
  logic            vsync_q;
  logic            tick;
  logic [HW-1:0]   hold_cnt;
  logic [DW-1:0]   deb_cnt;
  logic [DW-1:0]   deb_inc;
  logic [IW-1:0]   idle_cnt;
  logic [IW-1:0]   idle_inc;
  logic [3:0]      next_idx;
  logic [7:0]      next_pat;

  assign tick     = vsync_in & ~vsync_q;
  assign deb_inc  = deb_cnt + DW'(1);
  assign idle_inc = idle_cnt + IW'(1);
  assign next_idx = (char_index == 4'(MSG_LEN - 1)) ? 4'd0 : char_index + 4'd1;

  segment_msg_rom u_rom (
    .addr    (next_idx),
    .pattern (next_pat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // vsync_q starts high so a vsync already high at release is not an edge
      vsync_q     <= 1'b1;
      frame_tick  <= 1'b0;
      frame_count <= '0;
      state       <= PLAY;
      hold_cnt    <= '0;
      deb_cnt     <= '0;
      idle_cnt    <= '0;
      char_index  <= '0;
      led_pattern <= MSG[0];
      show_user   <= 1'b0;
    end else begin
      vsync_q    <= vsync_in;
      frame_tick <= tick;
      if (tick) begin
        frame_count <= frame_count + 10'd1;
        case (state)
          PLAY, ARM: begin
            if (hold_cnt == HW'(HOLD_FRAMES - 1)) begin
              hold_cnt    <= '0;
              char_index  <= next_idx;
              led_pattern <= next_pat;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
            // the user takeover below overrides the playback glyph on the same tick
            if (ui_in == 8'h00) begin
              state <= PLAY;
            end else if (state == PLAY && DEBOUNCE_FRAMES > 1) begin
              state   <= ARM;
              deb_cnt <= DW'(1);
            end else if (state == PLAY || deb_inc == DW'(DEBOUNCE_FRAMES)) begin
              state       <= USER;
              led_pattern <= ui_in;
              show_user   <= 1'b1;
              idle_cnt    <= '0;
            end else begin
              deb_cnt <= deb_inc;
            end
          end
          USER: begin
            led_pattern <= ui_in;
            if (ui_in != 8'h00) begin
              idle_cnt <= '0;
            end else if (idle_inc == IW'(IDLE_TIMEOUT)) begin
              state       <= PLAY;
              idle_cnt    <= '0;
              hold_cnt    <= '0;
              char_index  <= '0;
              led_pattern <= MSG[0];
              show_user   <= 1'b0;
            end else begin
              idle_cnt <= idle_inc;
            end
          end
          default: state <= PLAY;
        endcase
      end
    end
  end

endmodule
